fm_mod_tx: RTL
==============

FM_MOD_TX -- requirements
Module: fm_mod_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width of audio and of each of I/Q.
REQ-002 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-003 SHALL have parameter KF_SHIFT, default 8, left shift from audio sample to phase increment, setting frequency deviation.
REQ-004 SHALL have parameter PKG_LEN, default 128, number of I/Q samples per packet.
REQ-005 SHALL have parameter SYNC_WORD, default 32'hA5A5_5A5A, 2*WIDTH-bit header word.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset; it is asynchronous and active-low.
REQ-008 SHALL have port data_i, input, WIDTH bits, signed audio sample in Q1.15.
REQ-009 SHALL have port valid_i, input, 1 bit, data_i valid.
REQ-010 SHALL have port ready_o, output, 1 bit; a sample is accepted when valid_i and ready_o are both high.
REQ-011 SHALL have port data_o, output, 2*WIDTH bits, signed {real[31:16], imag[15:0]}, or SYNC_WORD.
REQ-012 SHALL have port valid_o, output, 1 bit, data_o valid; there is no downstream backpressure.
REQ-013 SHALL have port start_o, output, 1 bit, one-cycle pulse coincident with the first I/Q word of each packet.

Function
REQ-014 SHALL implement FSM IDLE -> SYNC -> DATA -> FLUSH -> IDLE.
- IDLE: ready_o=0; valid_i high moves to SYNC.
- SYNC: 1 cycle; output stage loads SYNC_WORD with valid_o=1.
- DATA: ready_o=1; counts accepted samples; the PKG_LEN-th accept moves to FLUSH.
- FLUSH: 3 cycles, ready_o=0, drains the pipeline; then IDLE.
REQ-015 SHALL, on each accepted sample, update phase = phase + (sext(data_i) <<< KF_SHIFT), truncated modulo 2^PHASE_W; wrap-around is silent and intended.
REQ-016 SHALL NOT reset phase between packets; phase is continuous across packets.
REQ-017 SHALL index the LUT with the top 10 phase bits: 2 quadrant bits plus an 8-bit quarter-wave address.
REQ-018 SHALL output I=cos(phase) and Q=sin(phase) scaled to ±32767, with quadrant sign/mirror folding.
REQ-019 SHALL use a 3-stage pipeline: accept -> phase register -> LUT read register -> fold/output register.
- Latency from accept to valid_o is exactly 3 cycles.
REQ-020 SHALL propagate gaps: valid_i low in DATA inserts a bubble; valid_o is low 3 cycles later; the count does not advance.
REQ-021 SHALL hold data_o at its last value when valid_o=0.
REQ-022 SHALL never have the SYNC output collide with pipeline output: the pipeline is empty in SYNC by construction.

Reset
REQ-023 SHALL, on rst low (asynchronously, including mid-packet), force:
- FSM=IDLE, phase=0, count=0, all pipeline valids=0;
- data_o=0, valid_o=0, start_o=0, ready_o=0.
REQ-024 SHALL discard in-flight samples; the first packet after reset begins with SYNC.

Configuration
REQ-025 SHALL, with macro FM_MOD_TX_PREEMPH_EN defined, apply pre-emphasis before the phase update.
- p[n] = sat(x[n] - (x[n-1] >>> 1)), saturated to WIDTH bits.
- x[n-1] updates only on accept and resets to 0.
- Latency and handshake are unchanged.
REQ-026 SHALL, without FM_MOD_TX_PREEMPH_EN, use data_i directly, with no extra registers.

Structure
REQ-027 SHALL place WIDTH, PHASE_W, SYNC_WORD default, the FSM state encoding, and the LUT depth constant in shared package fm_pkg.
- The demodulator-side pkg_detect uses the same package.
REQ-028 SHALL implement the quarter-wave ROM (256 x 15-bit, registered read) as sub-module sin_lut_q.
- The FSM, accumulator and fold logic stay in fm_mod_tx.

Verification
REQ-029 SHALL cover zero input: data_i=0 continuous -> after SYNC, every word is {32767, 0}.
REQ-030 SHALL cover quarter-cycle steps: data_i=16384 (increment 2^22) -> {32767,0}, {0,32767}, {-32767,0}, {0,-32767}, repeating.
REQ-031 SHALL cover framing: 2 back-to-back packets -> each shows SYNC_WORD, then 128 I/Q words, with start_o on word 1 only; phase is continuous across the boundary.
REQ-032 SHALL cover input gaps: valid_i toggled every other cycle -> valid_o pattern identical, delayed 3 cycles; still 128 words per packet.
REQ-033 SHALL cover reset mid-packet: rst low at sample 60 -> all outputs 0 immediately; next packet starts with SYNC_WORD then {32767,0} for data_i=0.
REQ-034 SHALL cover pre-emphasis (FM_MOD_TX_PREEMPH_EN): step 0 -> 16384 -> effective increments of 16384 then 8192 steady state, checked via the phase sequence.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared FM constants, FSM encoding and quarter-wave table generator.
// The receive side (pkg_detect) imports this same package.
package fm_pkg;

    localparam int          FM_WIDTH     = 16;
    localparam int          FM_PHASE_W   = 24;
    localparam logic [31:0] FM_SYNC_WORD = 32'hA5A5_5A5A;

    localparam int  LUT_AW    = 8;
    localparam int  LUT_DEPTH = 1 << LUT_AW;
    localparam int  LUT_DW    = 15;
    localparam real LUT_PI    = 3.14159265358979323846;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_FLUSH
    } fm_state_e;

    typedef logic [LUT_DEPTH-1:0][LUT_DW-1:0] lut_rom_t;

    // Entry k = round((2^15-1) * sin(k*pi/512)); only evaluated at elaboration.
    function automatic lut_rom_t gen_quarter_sine();
        lut_rom_t rom;
        real      amp;
        for (int k = 0; k < LUT_DEPTH; k++) begin
            amp    = $sin($itor(k) * LUT_PI / $itor(2 * LUT_DEPTH)) * $itor((1 << LUT_DW) - 1);
            rom[k] = LUT_DW'($rtoi(amp + 0.5));
        end
        return rom;
    endfunction

endpackage

// File: rtl/sin_lut_q.sv
// Quarter-wave sine ROM, 256 x 15 bit, two registered read ports so the
// sine and mirrored cosine addresses are looked up in the same cycle.
module sin_lut_q
    import fm_pkg::*;
(
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr_a_i,
    input  logic [LUT_AW-1:0] addr_b_i,
    output logic [LUT_DW-1:0] data_a_o,
    output logic [LUT_DW-1:0] data_b_o
);

    localparam lut_rom_t ROM = gen_quarter_sine();

    logic [LUT_DW-1:0] data_a_q, data_b_q;

    always_ff @(posedge clk) begin
        data_a_q <= ROM[addr_a_i];
        data_b_q <= ROM[addr_b_i];
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/fm_mod_tx.sv
// FM modulator with packet framing: SYNC_WORD header then PKG_LEN I/Q words.
// Optional pre-emphasis filter enabled by defining FM_MOD_TX_PREEMPH_EN.
module fm_mod_tx
    import fm_pkg::*;
#(
    parameter int                 WIDTH     = FM_WIDTH,
    parameter int                 PHASE_W   = FM_PHASE_W,
    parameter int                 KF_SHIFT  = 8,
    parameter int                 PKG_LEN   = 128,
    parameter logic [2*WIDTH-1:0] SYNC_WORD = FM_SYNC_WORD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [2*WIDTH-1:0]      data_o,
    output logic                    valid_o,
    output logic                    start_o
);

    localparam int STAGES = 3;
    localparam int CNT_W  = $clog2(PKG_LEN + 4);
    localparam int PH_TOP = LUT_AW + 2;

    fm_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      accept, is_sync, first_acc;
    logic signed [WIDTH-1:0]   samp;
    logic signed [PHASE_W-1:0] samp_ext;
    logic [PHASE_W-1:0]        inc, phase_q;
    logic [PH_TOP-1:0]         ph1_q;
    logic [1:0]                quad2_q;
    logic                      amax2_q;
    logic [LUT_AW-1:0]         addr_s, addr_c;
    logic [LUT_DW-1:0]         rom_s, rom_c;
    logic [STAGES-1:1]         vld_pipe_q, sop_pipe_q;
    logic signed [WIDTH-1:0]   sin_mag, cos_mag, i_d, q_d;
    logic [2*WIDTH-1:0]        data_q;
    logic                      valid_q, start_q;

    assign ready_o   = (state_q == ST_DATA);
    assign accept    = valid_i && ready_o;
    assign is_sync   = (state_q == ST_SYNC);
    assign first_acc = accept && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (valid_i) state_d = ST_SYNC;
            ST_SYNC: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: if (accept) begin
                if (cnt_q == CNT_W'(PKG_LEN - 1)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(STAGES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FM_MOD_TX_PREEMPH_EN
    logic signed [WIDTH-1:0] xprev_q;
    logic signed [WIDTH:0]   diff;

    // One extra bit of headroom, then clamp back to WIDTH.
    always_comb begin
        diff = (WIDTH+1)'(data_i) - (WIDTH+1)'(xprev_q >>> 1);
        if (diff[WIDTH] != diff[WIDTH-1])
            samp = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            samp = diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        xprev_q <= '0;
        else if (accept) xprev_q <= data_i;
    end
`else
    assign samp = data_i;
`endif

    assign samp_ext = PHASE_W'(samp);
    assign inc      = samp_ext <<< KF_SHIFT;

    // Stage 1: each word uses the phase reached before its own increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            ph1_q   <= '0;
        end else if (accept) begin
            phase_q <= phase_q + inc;
            ph1_q   <= phase_q[PHASE_W-1 -: PH_TOP];
        end
    end

    assign addr_s = ph1_q[LUT_AW-1:0];
    assign addr_c = LUT_AW'(0) - addr_s;

    sin_lut_q u_lut (
        .clk      (clk),
        .addr_a_i (addr_s),
        .addr_b_i (addr_c),
        .data_a_o (rom_s),
        .data_b_o (rom_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quad2_q    <= '0;
            amax2_q    <= 1'b0;
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
        end else begin
            quad2_q    <= ph1_q[PH_TOP-1 -: 2];
            amax2_q    <= (addr_s == '0);
            vld_pipe_q <= {vld_pipe_q[STAGES-2:1], accept};
            sop_pipe_q <= {sop_pipe_q[STAGES-2:1], first_acc};
        end
    end

    // cos at quadrant offset 0 needs entry 256, which sits just past the table.
    assign sin_mag = WIDTH'(rom_s);
    assign cos_mag = amax2_q ? WIDTH'((1 << LUT_DW) - 1) : WIDTH'(rom_c);

    always_comb begin
        i_d = cos_mag;
        q_d = sin_mag;
        case (quad2_q)
            2'd1: begin i_d = -sin_mag; q_d =  cos_mag; end
            2'd2: begin i_d = -cos_mag; q_d = -sin_mag; end
            2'd3: begin i_d =  sin_mag; q_d = -cos_mag; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else if (is_sync) begin
            data_q  <= SYNC_WORD;
            valid_q <= 1'b1;
            start_q <= 1'b0;
        end else begin
            valid_q <= vld_pipe_q[STAGES-1];
            start_q <= vld_pipe_q[STAGES-1] && sop_pipe_q[STAGES-1];
            if (vld_pipe_q[STAGES-1]) data_q <= {i_d, q_d};
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign start_o = start_q;

endmodule
